// File: rtl/alu_arbiter.sv
// Two-requester front end sharing one ALU: round-robin grant, a single held
// result, and a wrapping count of completed responses.

module alu (
   input  logic [3:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] out,
   output logic        is_out_zero,
   output logic        error
);
   // op = {funct7[5], funct3}; shifts use the whole b word, so b >= 32 saturates
   always_comb begin
      out   = '0;
      error = 1'b0;
      case (op)
         4'b0_000: out = a + b;
         4'b1_000: out = a - b;
         4'b0_001: out = a << b;
         4'b0_010: out = {31'b0, $signed(a) < $signed(b)};
         4'b0_011: out = {31'b0, a < b};
         4'b0_100: out = a ^ b;
         4'b0_101: out = a >> b;
         4'b1_101: out = 32'($signed(a) >>> b);
         4'b0_110: out = a | b;
         4'b0_111: out = a & b;
         default:  error = 1'b1;
      endcase
      is_out_zero = (out == '0);
   end
endmodule

module alu_arbiter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [3:0]       req_op0,
   input  logic [3:0]       req_op1,
   input  logic [31:0]      req_a0,
   input  logic [31:0]      req_b0,
   input  logic [31:0]      req_a1,
   input  logic [31:0]      req_b1,
   output logic [1:0]       resp_valid,
   input  logic [1:0]       resp_ready,
   output logic [31:0]      resp_out,
   output logic             resp_zero,
   output logic             resp_error,
   output logic [CNT_W-1:0] op_count
);
   typedef enum logic {IDLE, RESP} state_t;

   state_t             state_q, state_d;
   logic               last_grant_q, last_grant_d;
   logic               owner_q, owner_d;
   logic [31:0]        out_q, out_d;
   logic               zero_q, zero_d;
   logic               err_q, err_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic               gnt, accept, resp_hs;
   logic [3:0]         sel_op;
   logic [31:0]        sel_a, sel_b, alu_out;
   logic               alu_zero, alu_err;

   alu u_alu (
      .op          (sel_op),
      .a           (sel_a),
      .b           (sel_b),
      .out         (alu_out),
      .is_out_zero (alu_zero),
      .error       (alu_err)
   );

   // A tie goes to whoever was not granted last; reset leaves last_grant = 1
   always_comb begin
      gnt     = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];
      accept  = (state_q == IDLE) && (req_valid != 2'b00);
      resp_hs = (state_q == RESP) && resp_ready[owner_q];
      sel_op  = gnt ? req_op1 : req_op0;
      sel_a   = gnt ? req_a1  : req_a0;
      sel_b   = gnt ? req_b1  : req_b0;
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      owner_d      = owner_q;
      out_d        = out_q;
      zero_d       = zero_q;
      err_d        = err_q;
      cnt_d        = cnt_q;
      if (accept) begin
         state_d      = RESP;
         last_grant_d = gnt;
         owner_d      = gnt;
         out_d        = alu_out;
         zero_d       = alu_zero;
         err_d        = alu_err;
      end else if (resp_hs) begin
         state_d = IDLE;
         cnt_d   = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         owner_q      <= 1'b0;
         out_q        <= '0;
         zero_q       <= 1'b0;
         err_q        <= 1'b0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         owner_q      <= owner_d;
         out_q        <= out_d;
         zero_q       <= zero_d;
         err_q        <= err_d;
         cnt_q        <= cnt_d;
      end
   end

   assign req_ready  = accept ? (gnt ? 2'b10 : 2'b01) : 2'b00;
   assign resp_valid = (state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
   assign resp_out   = out_q;
   assign resp_zero  = zero_q;
   assign resp_error = err_q;
   assign op_count   = cnt_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and random checks of alu_arbiter against a transaction-level model;
// a second instance with a 2-bit counter tracks the wrapping count.

module tb_alu_arbiter;
   logic        clk, rst_n;
   logic [1:0]  req_valid, resp_ready;
   logic [3:0]  req_op0, req_op1;
   logic [31:0] req_a0, req_b0, req_a1, req_b1;
   logic [1:0]  req_ready, resp_valid, req_ready2, resp_valid2;
   logic [31:0] resp_out, resp_out2;
   logic        resp_zero, resp_error, resp_zero2, resp_error2;
   logic [15:0] op_count;
   logic [1:0]  op_count2;

   int checks = 0;
   int errors = 0;

   // model state: one outstanding transaction
   bit          m_busy;
   int          m_owner, m_last;
   logic [31:0] m_out;
   logic        m_zero, m_err;
   int          m_cnt;

   alu_arbiter u_dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_op0(req_op0), .req_op1(req_op1), .req_a0(req_a0), .req_b0(req_b0),
      .req_a1(req_a1), .req_b1(req_b1), .resp_valid(resp_valid),
      .resp_ready(resp_ready), .resp_out(resp_out), .resp_zero(resp_zero),
      .resp_error(resp_error), .op_count(op_count)
   );

   alu_arbiter #(.CNT_W(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready2),
      .req_op0(req_op0), .req_op1(req_op1), .req_a0(req_a0), .req_b0(req_b0),
      .req_a1(req_a1), .req_b1(req_b1), .resp_valid(resp_valid2),
      .resp_ready(resp_ready), .resp_out(resp_out2), .resp_zero(resp_zero2),
      .resp_error(resp_error2), .op_count(op_count2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output logic z, output logic e);
      r = 32'd0;
      e = 1'b0;
      case (op)
         4'b0000: r = a + b;
         4'b1000: r = a - b;
         4'b0001: r = (b > 31) ? 32'd0 : (a << b[4:0]);
         4'b0010: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'b0011: r = (a < b) ? 32'd1 : 32'd0;
         4'b0100: r = a ^ b;
         4'b0101: r = (b > 31) ? 32'd0 : (a >> b[4:0]);
         4'b1101: r = (b > 31) ? {32{a[31]}} : 32'($signed(a) >>> b[4:0]);
         4'b0110: r = a | b;
         4'b0111: r = a & b;
         default: e = 1'b1;
      endcase
      z = (r == 32'd0);
   endtask

   function automatic int grant_of(input logic [1:0] v, input int last);
      if (v == 2'b11) return (last == 0) ? 1 : 0;
      return v[1] ? 1 : 0;
   endfunction

   task automatic model_reset();
      m_busy = 0; m_owner = 0; m_last = 1;
      m_out = 32'd0; m_zero = 1'b0; m_err = 1'b0; m_cnt = 0;
   endtask

   task automatic check_resp(input string tag);
      chk({tag, ".resp_valid"}, {30'd0, resp_valid},
          m_busy ? ((m_owner == 1) ? 32'd2 : 32'd1) : 32'd0);
      chk({tag, ".resp_out"},   resp_out, m_out);
      chk({tag, ".resp_zero"},  {31'd0, resp_zero}, {31'd0, m_zero});
      chk({tag, ".resp_error"}, {31'd0, resp_error}, {31'd0, m_err});
      chk({tag, ".op_count"},   {16'd0, op_count}, m_cnt & 32'hFFFF);
      chk({tag, ".op_count2"},  {30'd0, op_count2}, m_cnt % 4);
   endtask

   // called with inputs already set just after a falling edge; returns on the next falling edge
   task automatic cycle(input string tag);
      int g;
      logic [31:0] r;
      logic z, e;
      g = grant_of(req_valid, m_last);
      #1;
      chk({tag, ".req_ready"}, {30'd0, req_ready},
          (!m_busy && req_valid != 2'b00) ? ((g == 1) ? 32'd2 : 32'd1) : 32'd0);
      if (!m_busy && req_valid != 2'b00) begin
         if (g == 1) ref_alu(req_op1, req_a1, req_b1, r, z, e);
         else        ref_alu(req_op0, req_a0, req_b0, r, z, e);
         m_busy = 1; m_owner = g; m_last = g;
         m_out = r; m_zero = z; m_err = e;
      end else if (m_busy && resp_ready[m_owner]) begin
         m_busy = 0;
         m_cnt++;
      end
      @(posedge clk);
      @(negedge clk);
      check_resp(tag);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      #1;
      check_resp("reset");
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b1;
      req_valid = 2'b00; resp_ready = 2'b00;
      req_op0 = 4'd0; req_op1 = 4'd0;
      req_a0 = 0; req_b0 = 0; req_a1 = 0; req_b1 = 0;
      model_reset();

      // reset values, and req_ready is live from IDLE while in reset
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_resp("por");
      req_valid = 2'b11;
      #1;
      chk("por.req_ready_tie", {30'd0, req_ready}, 32'd1);
      req_valid = 2'b00;
      @(negedge clk);
      rst_n = 1'b1;

      // single request ADD 10+7
      req_valid = 2'b01; req_op0 = 4'b0000; req_a0 = 10; req_b0 = 7; resp_ready = 2'b01;
      cycle("add.acc");
      chk("add.out17", resp_out, 32'd17);
      chk("add.rv", {30'd0, resp_valid}, 32'd1);
      req_valid = 2'b00;
      cycle("add.hs");
      chk("add.cnt1", {16'd0, op_count}, 32'd1);

      // tie after reset alternates 0,1,0,1
      do_reset();
      req_valid = 2'b11; resp_ready = 2'b11;
      req_op0 = 4'b1000; req_a0 = 20; req_b0 = 3;
      req_op1 = 4'b1101; req_a1 = 32'hFFFFFFFE; req_b1 = 1;
      for (int i = 0; i < 8; i++) begin
         cycle("tie");
         if (i % 2 == 0) begin
            chk("tie.owner", {30'd0, resp_valid}, (i % 4 == 0) ? 32'd1 : 32'd2);
            chk("tie.out", resp_out, (i % 4 == 0) ? 32'd17 : 32'hFFFFFFFF);
         end
      end
      chk("tie.cnt4", {16'd0, op_count}, 32'd4);

      // back-pressure on requester 1 SLT -2<5
      req_valid = 2'b10; req_op1 = 4'b0010; req_a1 = 32'hFFFFFFFE; req_b1 = 5; resp_ready = 2'b00;
      cycle("bp.acc");
      for (int i = 0; i < 5; i++) begin
         cycle("bp.stall");
         chk("bp.rv", {30'd0, resp_valid}, 32'd2);
         chk("bp.out1", resp_out, 32'd1);
      end
      resp_ready = 2'b01;
      cycle("bp.nonowner");
      chk("bp.still", {30'd0, resp_valid}, 32'd2);
      resp_ready = 2'b10; req_valid = 2'b00;
      cycle("bp.hs");
      chk("bp.done", {30'd0, resp_valid}, 32'd0);

      // illegal op
      req_valid = 2'b01; req_op0 = 4'b1111; req_a0 = 3; req_b0 = 4; resp_ready = 2'b01;
      cycle("ill.acc");
      chk("ill.err", {31'd0, resp_error}, 32'd1);
      chk("ill.out", resp_out, 32'd0);
      chk("ill.zero", {31'd0, resp_zero}, 32'd1);
      req_valid = 2'b00;
      cycle("ill.hs");

      // reset while holding a result
      req_valid = 2'b01; req_op0 = 4'b0100; req_a0 = 5; req_b0 = 5; resp_ready = 2'b00;
      cycle("rst.acc");
      chk("rst.held", {30'd0, resp_valid}, 32'd1);
      req_valid = 2'b00;
      do_reset();
      chk("rst.rv", {30'd0, resp_valid}, 32'd0);
      chk("rst.cnt", {16'd0, op_count}, 32'd0);
      req_valid = 2'b11; resp_ready = 2'b11;
      cycle("rst.tie");
      chk("rst.tie0", {30'd0, resp_valid}, 32'd1);
      req_valid = 2'b00;
      cycle("rst.hs");

      // narrow counter wraps 1,2,3,0,1
      do_reset();
      resp_ready = 2'b11;
      for (int k = 0; k < 5; k++) begin
         req_valid = 2'b01; req_op0 = 4'b0110; req_a0 = k; req_b0 = 1;
         cycle("wrap.acc");
         req_valid = 2'b00;
         cycle("wrap.hs");
         chk("wrap.cnt2", {30'd0, op_count2}, (k + 1) % 4);
      end

      // random traffic
      for (int i = 0; i < 400; i++) begin
         req_valid  = 2'($urandom_range(0, 3));
         resp_ready = 2'($urandom_range(0, 3));
         req_op0 = 4'($urandom); req_op1 = 4'($urandom);
         req_a0 = $urandom; req_a1 = $urandom;
         req_b0 = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 40) : $urandom;
         req_b1 = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 40) : $urandom;
         cycle("rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
